// File: rtl/dram64k8_ctrl_pkg.sv
// Shared types and default timing for the 64K x 8 DRAM sequencer.
// Pure declarations: no latency, no flow control.
package dram64k8_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAS,
        CAS,
        ACC,
        LAT,
        PRE,
        REF
    } state_t;

    typedef enum logic [1:0] {
        PORT_CPU,
        PORT_VID,
        PORT_REF
    } port_t;

    localparam int REFRESH_INTERVAL_DEF = 128;
    localparam int T_RAS_REF_DEF        = 3;
    localparam int T_PRE_DEF            = 1;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: raises one pending flag every INTERVAL cycles (extra expiries dropped);
// flag clears and the 8-bit row advances on the controller's single-cycle ref_clr.
module dram_refresh_timer
    import dram64k8_ctrl_pkg::*;
#(
    parameter int INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic       i_MCLK,
    input  logic       i_RST_n,
    input  logic       ref_clr,
    output logic       ref_pend,
    output logic [7:0] ref_row
);

    localparam int CW = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (cnt == CW'(INTERVAL - 1));

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cnt      <= '0;
            ref_pend <= 1'b0;
            ref_row  <= '0;
        end else begin
            cnt <= expire ? '0 : cnt + 1'b1;
            // A fresh expiry wins over a clear landing in the same cycle.
            if (expire)
                ref_pend <= 1'b1;
            else if (ref_clr)
                ref_pend <= 1'b0;
            if (ref_clr)
                ref_row <= ref_row + 8'd1;
        end
    end

endmodule

// File: rtl/dram64k8_ctrl.sv
// CPU/video DRAM arbiter and RAS/CAS sequencer; ACK 5 edges after grant, one access per 5+T_PRE cycles.
// Requests are held until ACK; refresh (DRAM_REFRESH_EN) only starts from IDLE and never aborts an access.
module dram64k8_ctrl
    import dram64k8_ctrl_pkg::*;
#(
`ifdef DRAM_REFRESH_EN
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
`endif
    parameter int T_RAS_REF = T_RAS_REF_DEF,
    parameter int T_PRE     = T_PRE_DEF
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WR,
    input  logic [15:0] i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DIN,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_CPU_DOUT,
    input  logic        i_VID_REQ,
    input  logic [15:0] i_VID_ADDR,
    output logic        o_VID_ACK,
    output logic [7:0]  o_VID_DOUT,
    output logic [7:0]  o_DRAM_ADDR,
    output logic [7:0]  o_DRAM_DIN,
    input  logic [7:0]  i_DRAM_DOUT,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n
);

    state_t      state;
    port_t       port;
    logic        cpu_next;
    logic [15:0] addr_q;
    logic [7:0]  din_q;
    logic        wr_q;
    logic [7:0]  tcnt;
    logic        ref_pend;
    logic [7:0]  ref_row;

`ifdef DRAM_REFRESH_EN
    logic ref_clr;

    assign ref_clr = (state == REF) && (tcnt == 8'(T_RAS_REF - 1));

    dram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh (
        .i_MCLK   (i_MCLK),
        .i_RST_n  (i_RST_n),
        .ref_clr  (ref_clr),
        .ref_pend (ref_pend),
        .ref_row  (ref_row)
    );
`else
    assign ref_pend = 1'b0;
    assign ref_row  = 8'h00;
`endif

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state       <= IDLE;
            port        <= PORT_CPU;
            cpu_next    <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            tcnt        <= '0;
            o_DRAM_ADDR <= '0;
            o_DRAM_DIN  <= '0;
            o_RAS_n     <= 1'b1;
            o_CAS_n     <= 1'b1;
            o_WR_n      <= 1'b1;
            o_CPU_ACK   <= 1'b0;
            o_VID_ACK   <= 1'b0;
            o_CPU_DOUT  <= '0;
            o_VID_DOUT  <= '0;
        end else begin
            o_CPU_ACK <= 1'b0;
            o_VID_ACK <= 1'b0;
            unique case (state)
                IDLE: begin
                    tcnt <= '0;
                    // cpu_next breaks ties between two held requests; refresh always wins.
                    if (ref_pend) begin
                        state       <= REF;
                        port        <= PORT_REF;
                        o_DRAM_ADDR <= ref_row;
                        o_RAS_n     <= 1'b0;
                    end else if (i_VID_REQ && (!i_CPU_REQ || !cpu_next)) begin
                        state       <= RAS;
                        port        <= PORT_VID;
                        cpu_next    <= 1'b1;
                        addr_q      <= i_VID_ADDR;
                        wr_q        <= 1'b0;
                        o_DRAM_ADDR <= i_VID_ADDR[7:0];
                        o_RAS_n     <= 1'b0;
                    end else if (i_CPU_REQ) begin
                        state       <= RAS;
                        port        <= PORT_CPU;
                        cpu_next    <= 1'b0;
                        addr_q      <= i_CPU_ADDR;
                        wr_q        <= i_CPU_WR;
                        din_q       <= i_CPU_DIN;
                        o_DRAM_ADDR <= i_CPU_ADDR[7:0];
                        o_RAS_n     <= 1'b0;
                    end
                end
                RAS: begin
                    state       <= CAS;
                    o_DRAM_ADDR <= addr_q[15:8];
                    o_CAS_n     <= 1'b0;
                end
                CAS: begin
                    state <= ACC;
                    if (wr_q) begin
                        o_WR_n     <= 1'b0;
                        o_DRAM_DIN <= din_q;
                    end
                end
                ACC: begin
                    state  <= LAT;
                    o_WR_n <= 1'b1;
                end
                LAT: begin
                    state   <= PRE;
                    tcnt    <= '0;
                    o_RAS_n <= 1'b1;
                    o_CAS_n <= 1'b1;
                    if (port == PORT_VID) begin
                        o_VID_ACK  <= 1'b1;
                        o_VID_DOUT <= i_DRAM_DOUT;
                    end else begin
                        o_CPU_ACK <= 1'b1;
                        if (!wr_q)
                            o_CPU_DOUT <= i_DRAM_DOUT;
                    end
                end
                PRE: begin
                    if (tcnt >= 8'(T_PRE - 1))
                        state <= IDLE;
                    else
                        tcnt <= tcnt + 8'd1;
                end
                REF: begin
                    if (tcnt == 8'(T_RAS_REF - 1)) begin
                        state   <= PRE;
                        tcnt    <= '0;
                        o_RAS_n <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram64k8_ctrl.sv
// Directed bench for dram64k8_ctrl with a behavioural 64K x 8 DRAM (registered read data).
// Table of single accesses, then arbitration, reset-during-write and refresh sequences.
module tb_dram64k8_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_dout;
    logic [7:0]  dram_addr, dram_din;
    logic [7:0]  dram_dout = '0;
    logic        ras_n, cas_n, wr_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram64k8_ctrl dut (
        .i_MCLK      (clk),
        .i_RST_n     (rst_n),
        .i_CPU_REQ   (cpu_req),
        .i_CPU_WR    (cpu_wr),
        .i_CPU_ADDR  (cpu_addr),
        .i_CPU_DIN   (cpu_din),
        .o_CPU_ACK   (cpu_ack),
        .o_CPU_DOUT  (cpu_dout),
        .i_VID_REQ   (vid_req),
        .i_VID_ADDR  (vid_addr),
        .o_VID_ACK   (vid_ack),
        .o_VID_DOUT  (vid_dout),
        .o_DRAM_ADDR (dram_addr),
        .o_DRAM_DIN  (dram_din),
        .i_DRAM_DOUT (dram_dout),
        .o_RAS_n     (ras_n),
        .o_CAS_n     (cas_n),
        .o_WR_n      (wr_n)
    );

    // DRAM model: row/column latched on strobe falling edges; initial contents 5A ^ row ^ col.
    logic [7:0] mem [0:65535];
    bit         mem_init = 1'b0;
    logic       ras_q = 1'b1, cas_q = 1'b1;
    logic [7:0] row_l = '0, col_l = '0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++)
                mem[i] <= 8'h5A ^ 8'(i) ^ 8'(i >> 8);
            mem_init <= 1'b1;
        end else begin
            ras_q <= ras_n;
            cas_q <= cas_n;
            if (ras_q && !ras_n) row_l <= dram_addr;
            if (cas_q && !cas_n) col_l <= dram_addr;
            if (!ras_n && !cas_n && !cas_q) begin
                if (!wr_n) mem[{col_l, row_l}] <= dram_din;
                dram_dout <= mem[{col_l, row_l}];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One access; latency counts posedges from request to ACK visible.
    task automatic do_access(input logic vid, input logic wr, input logic [15:0] addr,
                             input logic [7:0] din, output int lat, output logic [7:0] dout,
                             output logic [7:0] row, output logic [7:0] col,
                             output int wr_low, output int other_ack);
        lat = 0; wr_low = 0; other_ack = 0; row = '0; col = '0; dout = '0;
        @(posedge clk); #1;
        if (vid) begin
            vid_req = 1'b1; vid_addr = addr;
        end else begin
            cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_din = din;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                row = dram_addr;
                // Inputs changing after grant must not affect the access.
                vid_addr = ~addr; cpu_addr = ~addr; cpu_din = ~din;
            end
            if (lat == 2) col = dram_addr;
            if (!wr_n) wr_low++;
            if (vid ? cpu_ack : vid_ack) other_ack++;
            if (vid ? vid_ack : cpu_ack) begin
                dout = vid ? vid_dout : cpu_dout;
                break;
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
    endtask

    typedef struct {
        logic        vid;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int         lat, wl, oa, n, cyc;
        logic [7:0] d, r, c;
        logic [15:0] a;
        int         ack_port [4];
        int         ack_cyc [4];

        vecs[0] = '{1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 8'h3C, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h5A};
        vecs[6] = '{1'b0, 1'b1, 16'h00FF, 8'h81, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 8'h81};
        vecs[8] = '{1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h0B};

        do_reset();
        chk("reset strobes", {29'd0, ras_n, cas_n, wr_n}, 32'h7);
        chk("reset acks", {30'd0, cpu_ack, vid_ack}, 32'h0);
        chk("reset addr/din", {16'd0, dram_addr, dram_din}, 32'h0);
        chk("reset douts", {16'd0, cpu_dout, vid_dout}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            a = vecs[i].addr;
            do_access(vecs[i].vid, vecs[i].wr, a, vecs[i].din, lat, d, r, c, wl, oa);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd5);
            chk($sformatf("v%0d row", i), {24'd0, r}, {24'd0, a[7:0]});
            chk($sformatf("v%0d col", i), {24'd0, c}, {24'd0, a[15:8]});
            chk($sformatf("v%0d wr_n low cycles", i), 32'(wl), vecs[i].wr ? 32'd1 : 32'd0);
            chk($sformatf("v%0d other ack", i), 32'(oa), 32'd0);
            if (!vecs[i].wr)
                chk($sformatf("v%0d read data", i), {24'd0, d}, {24'd0, vecs[i].exp});
        end
        @(negedge clk);
        chk("cpu dout held", {24'd0, cpu_dout}, 32'h81);
        chk("vid dout held", {24'd0, vid_dout}, 32'h0B);

        // Both ports held: grants alternate video first, one access every 6 cycles.
        do_reset();
        @(posedge clk); #1;
        vid_req = 1'b1; vid_addr = 16'h0102;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0304;
        n = 0;
        for (cyc = 1; cyc <= 26; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (n < 4 && (vid_ack || cpu_ack)) begin
                ack_port[n] = vid_ack ? 1 : 0;
                ack_cyc[n]  = cyc;
                if (vid_ack) chk($sformatf("alt%0d vid data", n), {24'd0, vid_dout}, 32'h59);
                else         chk($sformatf("alt%0d cpu data", n), {24'd0, cpu_dout}, 32'h5D);
                n++;
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        chk("alt ack count", 32'(n), 32'd4);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("alt%0d port", k), 32'(ack_port[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d cycle", k), 32'(ack_cyc[k]), 32'(5 + 6 * k));
        end

        // Reset during the write strobe: strobes release at once and memory is untouched.
        do_reset();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h4321; cpu_din = 8'h77;
        n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clk);
            if (!wr_n) n = 1;
        end
        chk("wr_n reached low", 32'(n), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset strobes", {29'd0, ras_n, cas_n, wr_n}, 32'h7);
        chk("async reset acks", {30'd0, cpu_ack, vid_ack}, 32'h0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) n++;
        end
        chk("no ack after reset", 32'(n), 32'd0);
        do_access(1'b0, 1'b0, 16'h4321, 8'h00, lat, d, r, c, wl, oa);
        chk("old data kept", {24'd0, d}, 32'h38);
        chk("read after reset latency", 32'(lat), 32'd5);

`ifdef DRAM_REFRESH_EN
        begin
            int   nref, caslow, len;
            int   rows [16];
            int   lens [16];
            logic prev_ras;
            do_reset();
            nref = 0; caslow = 0; len = 0; prev_ras = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!cas_n) caslow++;
                if (!ras_n) begin
                    if (prev_ras && nref < 16) rows[nref] = int'(dram_addr);
                    len++;
                end else if (!prev_ras) begin
                    if (nref < 16) lens[nref] = len;
                    nref++;
                    len = 0;
                end
                prev_ras = ras_n;
            end
            chk("refresh count", 32'(nref), 32'd7);
            chk("refresh cas low", 32'(caslow), 32'd0);
            for (int k = 0; k < nref && k < 16; k++) begin
                chk($sformatf("refresh%0d row", k), 32'(rows[k]), 32'(k));
                chk($sformatf("refresh%0d ras width", k), 32'(lens[k]), 32'd3);
            end

            // Expiry at edge 128 lands inside an access granted at edge 125.
            do_reset();
            repeat (123) @(posedge clk);
            do_access(1'b0, 1'b0, 16'h0000, 8'h00, lat, d, r, c, wl, oa);
            chk("access across expiry latency", 32'(lat), 32'd5);
            chk("access across expiry data", {24'd0, d}, 32'h5A);
            n = 0; len = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (!ras_n) begin
                    if (len == 0) begin
                        n = i + 1;
                        chk("post-access refresh row", {24'd0, dram_addr}, 32'h0);
                    end
                    if (!cas_n) chk("post-access refresh cas", 32'd0, 32'd1);
                    len++;
                end
            end
            chk("refresh delay after ack", 32'(n), 32'd2);
            chk("post-access refresh width", 32'(len), 32'd3);
        end
`else
        begin
            int raslow;
            do_reset();
            raslow = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!ras_n) raslow++;
            end
            chk("idle ras low cycles", 32'(raslow), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
